switch_handshake_host: RTL and testbench

- Host-side counterpart of the picoMIPS switch/LED port; drives the switch bus the CPU reads.
- Accepts operand bytes on a valid/ready stream and presents each byte on the CPU inport lines (SW[7:0]).
- Pulses the CPU handshake line (SW[8]) for a fixed hold window, waits a settle window, then samples the CPU LED outport.
- Returns the sampled byte on a second valid/ready stream. Used for automated bring-up and regression of picoMIPS programs without manual switches.

---
 rtl/switch_handshake_host.sv | 162 ++++++++++++++++
 tb/tb_switch_handshake_host.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_handshake_host.sv
// switch_handshake_host
//   Host-side driver for the picoMIPS switch/LED port. Takes an operand byte
//   from a valid/ready stream and drives it onto the CPU switch lines. It then
//   pulses the handshake line for HOLD_CYCLES and waits SETTLE_CYCLES. After
//   that it samples the CPU LED outport and returns the sampled byte on a
//   second valid/ready stream.
//
//   Optional build macro SWITCH_HOST_LED_CHANGE_EN: the block snapshots
//   led_in when it accepts an operand. If led_in differs from that snapshot
//   for two consecutive SETTLE cycles, it samples early instead of waiting
//   for the full timeout.
//
// Ports
//   clk          in   system clock (shared with the picoMIPS core)
//   n_reset      in   asynchronous active-low reset
//   in_data      in   operand byte        in_valid  in  / in_ready  out
//   sw_data      out  CPU SW[7:0]         sw_handshake out  CPU SW[8]
//   led_in       in   CPU LED[7:0], same clock domain
//   res_data     out  sampled LED byte    res_valid out / res_ready in
//   busy         out  high in any state other than IDLE
//
// state   | meaning
// IDLE    | waiting for an operand, in_ready high
// DRIVE   | operand on sw_data, handshake high, counting HOLD_CYCLES
// SETTLE  | handshake low, waiting for the CPU result to settle
// PRESENT | sampled result offered on res_data until res_ready

module switch_handshake_host #(
  parameter int n             = 8,
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] sw_data,
  output logic         sw_handshake,
  input  logic [n-1:0] led_in,
  output logic [n-1:0] res_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy
);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, PRESENT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [n-1:0]     sw_data_q, sw_data_d;
  logic             hs_q, hs_d;
  logic [n-1:0]     res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
`ifdef SWITCH_HOST_LED_CHANGE_EN
  logic [n-1:0]     snap_q, snap_d;
  logic             chg_q, chg_d;
  logic             led_diff;
  assign led_diff = (led_in != snap_q);
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sw_data_q   <= '0;
      hs_q        <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
`ifdef SWITCH_HOST_LED_CHANGE_EN
      snap_q      <= '0;
      chg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sw_data_q   <= sw_data_d;
      hs_q        <= hs_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
`ifdef SWITCH_HOST_LED_CHANGE_EN
      snap_q      <= snap_d;
      chg_q       <= chg_d;
`endif
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sw_data_d   = sw_data_q;
    hs_d        = hs_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
`ifdef SWITCH_HOST_LED_CHANGE_EN
    snap_d      = snap_q;
    chg_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sw_data_d = in_data;
          hs_d      = 1'b1;
          cnt_d     = HOLD_LD;
          state_d   = DRIVE;
`ifdef SWITCH_HOST_LED_CHANGE_EN
          snap_d    = led_in;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          hs_d    = 1'b0;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
`ifdef SWITCH_HOST_LED_CHANGE_EN
        // chg_q remembers that the previous SETTLE cycle already saw a change
        chg_d = led_diff;
        if ((cnt_q == '0) || (led_diff && chg_q)) begin
`else
        if (cnt_q == '0) begin
`endif
          res_data_d  = led_in;
          res_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = PRESENT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PRESENT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: in_ready and busy decode the state; the rest are registers
  always_comb begin
    in_ready     = (state_q == IDLE);
    busy         = (state_q != IDLE);
    sw_data      = sw_data_q;
    sw_handshake = hs_q;
    res_data     = res_data_q;
    res_valid    = res_valid_q;
  end

endmodule

// File: tb/tb_switch_handshake_host.sv
module tb_switch_handshake_host;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;

  // default-parameter instance
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] sw_data;
  logic       sw_handshake;
  logic [7:0] led_in = '0;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic       busy;

  // HOLD_CYCLES=1, SETTLE_CYCLES=1 instance
  logic [7:0] f_in_data = '0;
  logic       f_in_valid = 1'b0;
  logic       f_in_ready;
  logic [7:0] f_sw_data;
  logic       f_hs;
  logic [7:0] f_led = '0;
  logic [7:0] f_res_data;
  logic       f_res_valid;
  logic       f_res_ready = 1'b1;
  logic       f_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_handshake_host u_dut (
    .clk(clk), .n_reset(n_reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sw_data(sw_data), .sw_handshake(sw_handshake), .led_in(led_in),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  switch_handshake_host #(.HOLD_CYCLES(1), .SETTLE_CYCLES(1)) u_fast (
    .clk(clk), .n_reset(n_reset),
    .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .sw_data(f_sw_data), .sw_handshake(f_hs), .led_in(f_led),
    .res_data(f_res_data), .res_valid(f_res_valid), .res_ready(f_res_ready),
    .busy(f_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] led;
    logic [7:0] exp_res;
    int         exp_hs;
    int         exp_lat;
  } vec_t;

  vec_t vecs [4];

  // Offer one operand at a negedge and follow it to res_valid.
  // lat counts clock edges from the accepting edge to the res_valid edge.
  task automatic run_op(input logic [7:0] d, input logic [7:0] led,
                        output int hs_cnt, output int lat, output logic [7:0] sw_seen);
    @(negedge clk);
    in_data  = d;
    led_in   = led;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sw_seen  = sw_data;
    hs_cnt   = 0;
    lat      = 0;
    while (!res_valid && lat < 200) begin
      if (sw_handshake) hs_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int hs_cnt, lat, k, rv_seen;
    logic [7:0] sw_seen, held;
    logic stable;

    vecs[0] = '{8'h5A, 8'hA5, 8'hA5, 4, 20};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 4, 20};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 4, 20};
    vecs[3] = '{8'h3C, 8'hC3, 8'hC3, 4, 20};

    // reset
    #12;
    chk("rst_sw_handshake", sw_handshake, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    n_reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_sw_data", sw_data, 8'h00);
    chk("idle_sw_handshake", sw_handshake, 1'b0);
    chk("idle_res_valid", res_valid, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // table-driven transactions, res_ready held high
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("v%0d_in_ready_pre", i), in_ready, 1'b1);
      run_op(vecs[i].din, vecs[i].led, hs_cnt, lat, sw_seen);
      chk($sformatf("v%0d_sw_data", i), sw_seen, vecs[i].din);
      chk($sformatf("v%0d_hs_cycles", i), hs_cnt, vecs[i].exp_hs);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_res_data", i), res_data, vecs[i].exp_res);
      chk($sformatf("v%0d_in_ready_pre_consume", i), in_ready, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready_post", i), in_ready, 1'b1);
      chk($sformatf("v%0d_res_valid_post", i), res_valid, 1'b0);
      chk($sformatf("v%0d_sw_data_kept", i), sw_data, vecs[i].din);
    end

    // backpressure: result held 30 cycles while 0x11 is offered
    res_ready = 1'b0;
    run_op(8'h77, 8'h9C, hs_cnt, lat, sw_seen);
    chk("bp_latency", lat, 20);
    held = res_data;
    chk("bp_res_data", held, 8'h9C);
    in_data  = 8'h11;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!res_valid || res_data !== held || in_ready !== 1'b0 || sw_data !== 8'h77)
        stable = 1'b0;
    end
    chk("bp_stable_30", stable, 1'b1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_after_consume", in_ready, 1'b1);
    chk("bp_res_valid_drop", res_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_sw_data", sw_data, 8'h11);
    chk("bp_accept_hs", sw_handshake, 1'b1);
    k = 0;
    while (!res_valid && k < 200) begin @(negedge clk); k++; end
    chk("bp_second_latency", k, 20);
    chk("bp_second_res", res_data, 8'h9C);
    @(negedge clk);

    // HOLD_CYCLES=1, SETTLE_CYCLES=1
    @(negedge clk);
    f_in_data  = 8'hC9;
    f_led      = 8'h42;
    f_in_valid = 1'b1;
    @(negedge clk);
    f_in_valid = 1'b0;
    chk("fast_sw_data", f_sw_data, 8'hC9);
    hs_cnt = 0;
    k = 0;
    while (!f_res_valid && k < 50) begin
      if (f_hs) hs_cnt++;
      @(negedge clk);
      k++;
    end
    chk("fast_hs_cycles", hs_cnt, 1);
    chk("fast_latency", k, 2);
    chk("fast_res_data", f_res_data, 8'h42);
    @(negedge clk);
    chk("fast_in_ready_post", f_in_ready, 1'b1);

    // asynchronous reset during DRIVE (cycle 2 of 4)
    @(negedge clk);
    in_data  = 8'hE1;
    led_in   = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_drive_hs_before", sw_handshake, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    chk("async_rst_hs", sw_handshake, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_sw_data", sw_data, 8'h00);
    @(negedge clk);
    n_reset = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid || busy) rv_seen++;
    end
    chk("post_rst_no_result", rv_seen, 0);
    run_op(8'h33, 8'h4D, hs_cnt, lat, sw_seen);
    chk("post_rst_sw_data", sw_seen, 8'h33);
    chk("post_rst_hs", hs_cnt, 4);
    chk("post_rst_latency", lat, 20);
    chk("post_rst_res", res_data, 8'h4D);
    @(negedge clk);

    // led_in step during SETTLE
    @(negedge clk);
    in_data  = 8'h21;
    led_in   = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 200) begin
      if (k == 6) led_in = 8'h07;
      @(negedge clk);
      k++;
    end
`ifdef SWITCH_HOST_LED_CHANGE_EN
    chk("led_change_latency", k, 8);
`else
    chk("led_change_latency", k, 20);
`endif
    chk("led_change_res", res_data, 8'h07);
    @(negedge clk);

    // unchanged led_in always times out
    run_op(8'h44, 8'h07, hs_cnt, lat, sw_seen);
    chk("led_static_latency", lat, 20);
    chk("led_static_res", res_data, 8'h07);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
